xgriscv_dmem_ctrl: RTL

//   Data-memory access controller between the xgriscv core's MEM stage and a wait-stated data SRAM.

---
 rtl/xgriscv_dmem_ctrl_pkg.sv | 30 +++
 rtl/xgriscv_lsu_align.sv | 46 ++++
 rtl/xgriscv_dmem_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/xgriscv_dmem_ctrl_pkg.sv
// Shared definitions for the xgriscv data-memory controller: access size codes,
// FSM state encoding and address-offset helpers.
package xgriscv_dmem_ctrl_pkg;

   // Access size codes carried on req_size; 2'b11 is reserved and treated as word.
   localparam logic [1:0] XG_SIZE_B = 2'b00;
   localparam logic [1:0] XG_SIZE_H = 2'b01;
   localparam logic [1:0] XG_SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StDone   = 2'd2
   } dmem_state_e;

   // Byte offset with the bits that would break natural alignment cleared.
   function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
      case (size)
         XG_SIZE_B: return off;
         XG_SIZE_H: return {off[1], 1'b0};
         default:   return 2'b00;
      endcase
   endfunction

   // True when the offset is not a multiple of the access size.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return off != align_off(size, off);
   endfunction

endpackage

// File: rtl/xgriscv_lsu_align.sv
// Combinational lane steering for the data-memory controller: byte strobes and
// lane-replicated store data on the way out, lane extraction plus sign/zero
// extension of the read word on the way back. The offset must already be aligned.
module xgriscv_lsu_align
   import xgriscv_dmem_ctrl_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic        uns,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [31:0] rsh_b;
   logic [31:0] rsh_h;

   // Strobe/replication for stores and lane extraction for loads, selected by size.
   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      rdata_ext = rword;
      rsh_b     = rword >> {off, 3'b000};
      rsh_h     = rword >> {off[1], 4'b0000};
      case (size)
         XG_SIZE_B: begin
            be        = 4'b0001 << off;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{~uns & rsh_b[7]}}, rsh_b[7:0]};
         end
         XG_SIZE_H: begin
            be        = 4'b0011 << {off[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{~uns & rsh_h[15]}}, rsh_h[15:0]};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            rdata_ext = rword;
         end
      endcase
   end

endmodule

// File: rtl/xgriscv_dmem_ctrl.sv
// Data-memory access controller between the MEM stage and a wait-stated SRAM.
// One request at a time: IDLE -> ACCESS -> DONE -> IDLE, with an ACCESS timeout.
// Optional build macro: XGRISCV_DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word requests skip ACCESS and complete with rsp_err; otherwise the low
// address bits are cleared and the access proceeds.
module xgriscv_dmem_ctrl
   import xgriscv_dmem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   dmem_state_e       state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [1:0]        off_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;

   logic              accept;
   logic [1:0]        off_req;
   logic [1:0]        size_sel;
   logic [1:0]        off_sel;
   logic [3:0]        be_calc;
   logic [31:0]       wdata_calc;
   logic [31:0]       rdata_calc;

   assign accept  = req_valid && (state_q == StIdle);
   assign off_req = align_off(req_size, req_addr[1:0]);

   // The aligner is shared: request fields while idle (store side), latched fields
   // during ACCESS (load extraction).
   assign size_sel = (state_q == StIdle) ? req_size : size_q;
   assign off_sel  = (state_q == StIdle) ? off_req  : off_q;

   xgriscv_lsu_align u_align (
      .size      (size_sel),
      .off       (off_sel),
      .wdata     (req_wdata),
      .uns       (uns_q),
      .rword     (mem_rdata),
      .be        (be_calc),
      .wdata_rep (wdata_calc),
      .rdata_ext (rdata_calc)
   );

   // FSM state, timeout counter and response registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Request latch: everything the memory side needs is frozen at accept time.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q    <= 1'b0;
         size_q  <= XG_SIZE_B;
         uns_q   <= 1'b0;
         off_q   <= 2'b00;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= req_we;
         size_q  <= req_size;
         uns_q   <= req_unsigned;
         off_q   <= off_req;
         addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
         be_q    <= be_calc;
         wdata_q <= wdata_calc;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      req_ready = (state_q == StIdle);
      mem_en    = (state_q == StAccess);
      rsp_valid = (state_q == StDone);
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d = StAccess;
               cnt_d   = '0;
               rdata_d = '0;
               err_d   = 1'b0;
`ifdef XGRISCV_DMEM_MISALIGN_TRAP_EN
               if (is_misaligned(req_size, req_addr[1:0])) begin
                  state_d = StDone;
                  err_d   = 1'b1;
               end
`endif
            end
         end
         StAccess: begin
            if (mem_ack) begin
               state_d = StDone;
               err_d   = 1'b0;
               rdata_d = we_q ? 32'h0 : rdata_calc;
            end else if (cnt_q == CntLast) begin
               state_d = StDone;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            // Response registers only hold data during the DONE pulse.
            state_d = StIdle;
            rdata_d = '0;
            err_d   = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   assign mem_we    = mem_en & we_q;
   assign mem_be    = be_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
